// File: rtl/ddr3_rd_arb_pkg.sv
// Shared types and default widths for the DDR3 burst-read arbiter.
package ddr3_rd_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 25;
  localparam int unsigned LEN_W_DEF  = 10;
  localparam int unsigned DATA_W_DEF = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_LOCAL,
    S_DONE
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       win_valid_o,
  output logic       win_idx_o
);

  always_comb begin
    win_valid_o = |req_i;
    win_idx_o   = (req_i == 2'b11) ? ~last_grant_i : req_i[1];
  end

endmodule

// File: rtl/ddr3_rd_arbiter.sv
// Shares one DDR3 burst-read port between two requesters with round-robin
// priority; returned beats and finish are routed to the granted port only.
module ddr3_rd_arbiter #(
  parameter int unsigned ADDR_W = ddr3_rd_arb_pkg::ADDR_W_DEF,
  parameter int unsigned LEN_W  = ddr3_rd_arb_pkg::LEN_W_DEF,
  parameter int unsigned DATA_W = ddr3_rd_arb_pkg::DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_rd_req,
  input  logic [LEN_W-1:0]  p0_rd_len,
  input  logic [ADDR_W-1:0] p0_rd_addr,
  output logic              p0_rd_ready,
  output logic              p0_rd_data_valid,
  output logic              p0_rd_finish,
  output logic [DATA_W-1:0] p0_rd_data,
  input  logic              p1_rd_req,
  input  logic [LEN_W-1:0]  p1_rd_len,
  input  logic [ADDR_W-1:0] p1_rd_addr,
  output logic              p1_rd_ready,
  output logic              p1_rd_data_valid,
  output logic              p1_rd_finish,
  output logic [DATA_W-1:0] p1_rd_data,
  output logic              rd_ddr3_req,
  output logic [LEN_W-1:0]  rd_ddr3_len,
  output logic [ADDR_W-1:0] rd_ddr3_addr,
  input  logic              rd_ddr3_data_valid,
  input  logic [DATA_W-1:0] rd_ddr3_data,
  input  logic              rd_ddr3_finish,
  input  logic              rd_ddr3_ready,
  output logic              grant,
  output logic              beat_err
);
  import ddr3_rd_arb_pkg::*;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [LEN_W:0]    cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              win_valid, win_idx;
  logic [LEN_W-1:0]  sel_len;
  logic [LEN_W:0]    cnt_inc, cnt_tot;
  logic              local_fin, in_burst;

  rr_pick2 u_pick (
    .req_i        ({p1_rd_req, p0_rd_req}),
    .last_grant_i (last_grant_q),
    .win_valid_o  (win_valid),
    .win_idx_o    (win_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    len_d        = len_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    local_fin    = 1'b0;
    p0_rd_ready  = 1'b0;
    p1_rd_ready  = 1'b0;
    sel_len      = win_idx ? p1_rd_len : p0_rd_len;
    cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    cnt_tot      = rd_ddr3_data_valid ? cnt_inc : cnt_q;

    case (state_q)
      S_IDLE: begin
        p0_rd_ready = rd_ddr3_ready;
        p1_rd_ready = rd_ddr3_ready;
        if (win_valid && rd_ddr3_ready) begin
          grant_d = win_idx;
          addr_d  = win_idx ? p1_rd_addr : p0_rd_addr;
          len_d   = sel_len;
          cnt_d   = '0;
          if (sel_len != '0) begin
            req_d   = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_LOCAL;
          end
        end
      end
      S_REQ: begin
        if (rd_ddr3_data_valid) begin
          req_d   = 1'b0;
          cnt_d   = cnt_tot;
          state_d = S_DATA;
        end
        // A finish here (with or without a first beat) ends the burst; the
        // length check is the same one applied in S_DATA.
        if (rd_ddr3_finish) begin
          req_d   = 1'b0;
          cnt_d   = cnt_tot;
          state_d = S_DONE;
          if (cnt_tot != {1'b0, len_q}) err_d = 1'b1;
        end
      end
      S_DATA: begin
        cnt_d = cnt_tot;
        if (rd_ddr3_finish) begin
          state_d = S_DONE;
          if (cnt_tot != {1'b0, len_q}) err_d = 1'b1;
        end
      end
      S_LOCAL: begin
        local_fin = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_burst = (state_q == S_REQ) || (state_q == S_DATA);

  assign p0_rd_data_valid = rd_ddr3_data_valid & in_burst & ~grant_q;
  assign p1_rd_data_valid = rd_ddr3_data_valid & in_burst & grant_q;
  assign p0_rd_finish     = ((rd_ddr3_finish & in_burst) | local_fin) & ~grant_q;
  assign p1_rd_finish     = ((rd_ddr3_finish & in_burst) | local_fin) & grant_q;
  assign p0_rd_data       = rd_ddr3_data;
  assign p1_rd_data       = rd_ddr3_data;

  assign rd_ddr3_req  = req_q;
  assign rd_ddr3_addr = addr_q;
  assign rd_ddr3_len  = len_q;
  assign grant        = grant_q;
  assign beat_err     = err_q;

endmodule

// File: doc/ddr3_rd_arbiter.md
# ddr3_rd_arbiter

Shares the single DDR3 burst-read port of the memory controller between two burst-read requesters. Port 0 is the rotation pixel-block reader and port 1 is the display/frame reader. The block grants one requester at a time with round-robin priority and forwards its address and length to the controller. It routes the returned beats and the finish strobe back to the granted port only. It sits between the requesters and the DDR3 controller read interface, in the `clk` domain.

## Interface
- `ADDR_W`, 25, DDR3 burst address width
- `LEN_W`, 10, burst length width (beats, not bytes)
- `DATA_W`, 64, read data width
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  reset, synchronous and active-high
- `p0_rd_req`, `p1_rd_req`  in  1  burst request; held high by the requester until its first `pN_rd_data_valid`
- `p0_rd_len`, `p1_rd_len`  in  LEN_W  burst length
- `p0_rd_addr`, `p1_rd_addr`  in  ADDR_W  burst base address
- `p0_rd_ready`, `p1_rd_ready`  out  1  arbiter can accept a request
- `p0_rd_data_valid`, `p1_rd_data_valid`  out  1  beat valid for this port
- `p0_rd_finish`, `p1_rd_finish`  out  1  burst complete for this port
- `pN_rd_data`  out  DATA_W  read data; one shared bus fanned out to both ports
- `rd_ddr3_req`  out  1  request to the controller
- `rd_ddr3_len`  out  LEN_W  latched length
- `rd_ddr3_addr`  out  ADDR_W  latched address
- `rd_ddr3_data_valid`  in  1  beat valid from the controller
- `rd_ddr3_data`  in  DATA_W  beat data from the controller
- `rd_ddr3_finish`  in  1  burst finished, from the controller
- `rd_ddr3_ready`  in  1  controller idle
- `grant`  out  1  currently or last granted port
- `beat_err`  out  1  sticky flag: the beat count did not equal the length when finish arrived

## Operation
States:
- **S_IDLE**
  - `pN_rd_ready = rd_ddr3_ready`; all other states drive both ready outputs to 0.
  - If any request is high and `rd_ddr3_ready` is 1: choose the winner. If only one port requests, it wins. If both request, the port not equal to `last_grant` wins.
  - Latch the winner's `addr`, `len` and index into `rd_ddr3_addr`, `rd_ddr3_len` and `grant`.
  - If the latched len != 0: set `rd_ddr3_req` to 1, clear the beat counter, go to S_REQ.
  - If the latched len == 0: do not access DDR3 and go to S_LOCAL.
- **S_REQ**
  - On `rd_ddr3_data_valid`: clear `rd_ddr3_req`, count one beat, go to S_DATA.
  - If `rd_ddr3_finish` arrives on the same cycle, go directly to S_DONE.
  - If `rd_ddr3_finish` arrives with no beat: clear `rd_ddr3_req` and go to S_DONE.
- **S_DATA**
  - Count each valid beat.
  - On `rd_ddr3_finish`: go to S_DONE. If the total beat count (including a beat on the finish cycle) != `rd_ddr3_len`, set `beat_err`.
- **S_LOCAL**
  - Pulse `pN_rd_finish` of the granted port for one cycle, go to S_DONE.
- **S_DONE**
  - `last_grant <= grant`, then go to S_IDLE. This leaves a mandatory one-cycle gap between bursts.

Routing:
- `pN_rd_data_valid = rd_ddr3_data_valid & (grant == N) & state in {S_REQ, S_DATA}`.
- `pN_rd_finish` uses the same gating, plus the S_LOCAL pulse.
- Beats arriving in S_IDLE or S_DONE are dropped.
- `pN_rd_data = rd_ddr3_data` unconditionally.

Beat counter: LEN_W+1 bits, saturating.

## Timing
- Reset values:
  - `rd_ddr3_req` = 0, `rd_ddr3_addr` = 0, `rd_ddr3_len` = 0
  - `grant` = 0, `last_grant` = 1 (port 0 wins the first tie), `beat_err` = 0
  - state = S_IDLE
  - all `pN_rd_data_valid` and `pN_rd_finish` = 0
- Grant latency: a request sampled in S_IDLE with ready high puts `rd_ddr3_req`, addr and len on the controller port on the next edge.
- `rd_ddr3_req` falls on the edge after the first valid beat.
- Data and finish routing is combinational, with 0-cycle latency.
- Back-to-back throughput: finish at cycle t gives S_DONE at t+1, S_IDLE at t+2, and the next `rd_ddr3_req` at t+3.
- A requester that drops its req before being granted is not serviced. Its held addr and len are ignored until it raises req again.
- Reset in mid-burst: everything returns to reset values on the next edge. Later controller beats and finish are dropped, and no port sees them.
- `beat_err` is cleared only by `rst`.

## Structure
- Package `ddr3_rd_arb_pkg`:
  - state enum (S_IDLE, S_REQ, S_DATA, S_LOCAL, S_DONE)
  - default widths ADDR_W, LEN_W, DATA_W
- Sub-module `rr_pick2`: combinational two-way round-robin pick from (req[1:0], last_grant) to (win_valid, win_idx).
- The FSM, latches, beat counter and routing live in `ddr3_rd_arbiter`.

## Test plan
- **Single port 0.** Stimulus: addr=0x000100, len=4, 4 beats, finish on beat 4. Expected: `rd_ddr3_addr`=0x000100 and `rd_ddr3_len`=4 one cycle later; `p0_rd_data_valid` ×4 with the data intact; `p1_rd_data_valid` stays 0; `beat_err`=0.
- **Simultaneous requests after reset.** Stimulus: p0 addr=0x10 and p1 addr=0x20, both len=4. Expected: p0 is served first; p1's `rd_ddr3_req` rises exactly 3 cycles after p0's finish.
- **Continuous requests.** Stimulus: both ports request repeatedly for 6 bursts. Expected: grants strictly alternate 0,1,0,1,0,1.
- **Length mismatch and zero length.** Stimulus: len=4 with finish after 3 beats. Expected: `beat_err` goes to 1 and stays 1. Stimulus: len=0 on p1. Expected: no `rd_ddr3_req`, and `p1_rd_finish` is a one-cycle pulse.
- **Reset mid-burst.** Stimulus: `rst` after beat 2 of 4, then 2 more beats and finish from the controller. Expected: `rd_ddr3_req`=0, both `pN_rd_data_valid`=0, `grant`=0, state S_IDLE.
- **Controller not ready.** Stimulus: `rd_ddr3_ready`=0 while p0 requests. Expected: no grant and `p0_rd_ready`=0. The grant issues on the cycle after ready rises.
